// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 8;
   localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      ZERO   = 2'd2,
      FINISH = 2'd3
   } div_state_e;

   // Iteration counter width; never narrower than one bit.
   function automatic int div_cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the partial
// remainder left by one, pulling in the next dividend bit, then subtract
// the divisor if it fits and record a quotient 1.
module div_step import div_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] r_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] r_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   shift_s;
   logic [WIDTH-1:0] diff_s;

   // Shift, compare on WIDTH+1 bits so the compare cannot overflow, restore.
   always_comb begin
      shift_s = {r_in, q_in[WIDTH-1]};
      diff_s  = shift_s[WIDTH-1:0] - divisor;
      q_out   = {q_in[WIDTH-2:0], 1'b0};
      if (shift_s >= {1'b0, divisor}) begin
         r_out    = diff_s;
         q_out[0] = 1'b1;
      end else begin
         r_out    = shift_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/seq_div.sv
// Iterative radix-2 restoring divider. WIDTH iterations per request.
// Optional macro SEQ_DIV_SIGNED_EN: two's-complement operands, truncating
// toward zero (sign fixup applied in FINISH, latency unchanged).
module seq_div import div_pkg::*; #(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = div_cnt_width(WIDTH);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] step_r_s, step_q_s;
`ifdef SEQ_DIV_SIGNED_EN
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
`endif

   // Operand magnitude fed to the unsigned core.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
`ifdef SEQ_DIV_SIGNED_EN
      return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
`else
      return x;
`endif
   endfunction

   div_step #(.WIDTH(WIDTH)) u_step (
      .r_in    (r_q),
      .q_in    (q_q),
      .divisor (dvs_q),
      .r_out   (step_r_s),
      .q_out   (step_q_s)
   );

   // Next-state, datapath update and result capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      // busy covers the done cycle, then drops so the next request needs one idle cycle
      if (done_q) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      case (state_q)
         IDLE: begin
            if (start && !busy_q) begin
               busy_d = 1'b1;
               cnt_d  = '0;
               dvs_d  = mag(divisor);
               q_d    = mag(dividend);
               r_d    = '0;
`ifdef SEQ_DIV_SIGNED_EN
               qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               rneg_d = dividend[WIDTH-1];
`endif
               if (divisor == '0) begin
                  r_d     = dividend;
                  state_d = ZERO;
               end else begin
                  state_d = CALC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            r_d   = step_r_s;
            q_d   = step_q_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FINISH;
            end else begin
               state_d = CALC;
            end
         end
         ZERO: begin
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            rem_d   = r_q;
`ifdef SEQ_DIV_SIGNED_EN
            quot_d  = rneg_q ? WIDTH'(1) : {WIDTH{1'b1}};
`else
            quot_d  = {WIDTH{1'b1}};
`endif
            state_d = IDLE;
         end
         FINISH: begin
            done_d  = 1'b1;
            dbz_d   = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            quot_d  = qneg_q ? (~q_q + WIDTH'(1)) : q_q;
            rem_d   = rneg_q ? (~r_q + WIDTH'(1)) : r_q;
`else
            quot_d  = q_q;
            rem_d   = r_q;
`endif
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=8).
module tb_seq_div;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks;
   int n_errors;

   seq_div #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One request: exp_lat is the number of edges after the accept edge at which done appears.
   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input logic [W-1:0] exp_q,
                          input logic [W-1:0] exp_r, input logic exp_z);
      int m;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
      m = 0;
      while (!done && m < 40) begin
         @(posedge clk);
         #1;
         m++;
      end
      check_val({tag, "_latency"}, m, exp_lat);
      check_val({tag, "_quot"}, {24'd0, quotient}, {24'd0, exp_q});
      check_val({tag, "_rem"}, {24'd0, remainder}, {24'd0, exp_r});
      check_val({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
      check_val({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check_val({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
      check_val({tag, "_quot_hold"}, {24'd0, quotient}, {24'd0, exp_q});
   endtask

   initial begin
      int first_done;
      int n_done;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_quot", {24'd0, quotient}, 32'd0);
      check_val("rst_rem", {24'd0, remainder}, 32'd0);
      check_val("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_div("d100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
      run_div("d5_0", 8'd5, 8'd0, 1, 8'hFF, 8'd5, 1'b1);
      run_div("d3_200", 8'd3, 8'd200, 9, 8'd0, 8'd3, 1'b0);
      run_div("d255_1", 8'd255, 8'd1, 9, 8'hFF, 8'd0, 1'b0);
      run_div("d0_5", 8'd0, 8'd5, 9, 8'd0, 8'd0, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
      run_div("s_m100_7", 8'h9C, 8'h07, 9, 8'hF2, 8'hFE, 1'b0);
      run_div("s_100_m7", 8'h64, 8'hF9, 9, 8'hF2, 8'h02, 1'b0);
      run_div("s_m128_m1", 8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0);
      run_div("s_m5_0", 8'hFB, 8'h00, 1, 8'h01, 8'hFB, 1'b1);
`else
      run_div("d255_255", 8'd255, 8'd255, 9, 8'd1, 8'd0, 1'b0);
      run_div("d200_13", 8'd200, 8'd13, 9, 8'd15, 8'd5, 1'b0);
`endif

      // start held high: accept at edge 0, done at 9, busy drops at 10,
      // re-accept at 11, done at 20; exactly two pulses within 25 edges.
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      first_done = -1;
      n_done = 0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
      end
      check_val("held_first_done", first_done, 32'd9);
      check_val("held_done_count", n_done, 32'd2);
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check_val("held_idle", {31'd0, busy}, 32'd0);

      // reset during CALC cycle 4 aborts with no done
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_quot", {24'd0, quotient}, 32'd0);
      check_val("abort_rem", {24'd0, remainder}, 32'd0);
      check_val("abort_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check_val("abort_no_done", n_done, 32'd0);
      run_div("after_rst", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);

`ifndef SEQ_DIV_SIGNED_EN
      // random unsigned pairs against the division identity
      for (int i = 0; i < 1500; i++) begin
         int m;
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(1, 255));
         @(negedge clk);
         dividend = ra;
         divisor  = rb;
         start    = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         m = 0;
         while (!done && m < 40) begin
            @(posedge clk);
            #1;
            m++;
         end
         check_val("rand_latency", m, 32'd9);
         check_val("rand_identity", 32'(quotient) * 32'(rb) + 32'(remainder), 32'(ra));
         check_val("rand_rem_lt", {31'd0, (remainder < rb)}, 32'd1);
         @(posedge clk);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
